// File: rtl/spi_client_ovs.sv
// SPI client with oversampled (synchronised) SCLK/CS/MOSI, a TX FIFO feeding MISO
// and a word-parallel RX output. All logic runs on i_spi_clk.
module spi_client_ovs #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic                           i_spi_clk,
    input  logic                           i_reset,
    input  logic                           i_sclk,
    input  logic                           i_cs_n,
    input  logic                           i_mosi,
    output logic                           o_miso,
    output logic                           o_active,
    output logic                           o_rx_valid,
    output logic                           o_rx_start,
    output logic [WIDTH-1:0]               o_rx_data,
    input  logic                           i_tx_valid,
    output logic                           o_tx_ready,
    input  logic [WIDTH-1:0]               i_tx_data,
    output logic                           o_tx_underrun,
    output logic [$clog2(DEPTH+1)-1:0]     o_tx_level,
    output logic [1:0]                     o_dbg_state
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic IDLE_LVL = (CPOL != 0);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACTIVE = 2'd1, ST_HOLD = 2'd2} state_t;

    state_t            state_q, state_d;
    logic              sclk_m_q, sclk_m_d, sclk_s_q, sclk_s_d, sclk_p_q, sclk_p_d;
    logic              cs_m_q, cs_m_d, cs_s_q, cs_s_d, cs_p_q, cs_p_d;
    logic              mosi_m_q, mosi_m_d, mosi_s_q, mosi_s_d;
    logic [WIDTH-1:0]  rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic              rx_valid_q, rx_valid_d, rx_start_q, rx_start_d, first_q, first_d;
    logic [WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic              miso_q, miso_d, underrun_q, underrun_d, active_q, active_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [WIDTH-1:0]  fifo_mem [DEPTH];

    logic              lead, trail, sample, shift, cs_fall;
    logic              push, pop, load, fifo_empty;
    logic [WIDTH-1:0]  rx_next, tx_next, tx_word;

    // Push handshake: a word is accepted on a rising clock edge where
    // i_tx_valid && o_tx_ready; o_tx_ready depends only on current occupancy.
    assign o_tx_ready = (level_q < LW'(DEPTH));
    assign push       = i_tx_valid && o_tx_ready;
    assign fifo_empty = (level_q == '0);

    assign lead    = (sclk_p_q == IDLE_LVL) && (sclk_s_q != IDLE_LVL);
    assign trail   = (sclk_p_q != IDLE_LVL) && (sclk_s_q == IDLE_LVL);
    assign sample  = (CPHA == 0) ? lead : trail;
    assign shift   = (CPHA == 0) ? trail : lead;
    assign cs_fall = cs_p_q && !cs_s_q;

    assign rx_next = (MSB_FIRST != 0) ? {rx_shift_q[WIDTH-2:0], mosi_s_q}
                                      : {mosi_s_q, rx_shift_q[WIDTH-1:1]};
    assign tx_next = (MSB_FIRST != 0) ? {tx_shift_q[WIDTH-2:0], 1'b0}
                                      : {1'b0, tx_shift_q[WIDTH-1:1]};
    assign tx_word = fifo_empty ? '0 : fifo_mem[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        sclk_m_d   = i_sclk;
        sclk_s_d   = sclk_m_q;
        sclk_p_d   = sclk_s_q;
        cs_m_d     = i_cs_n;
        cs_s_d     = cs_m_q;
        cs_p_d     = cs_s_q;
        mosi_m_d   = i_mosi;
        mosi_s_d   = mosi_m_q;
        active_d   = !cs_s_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_cnt_d   = rx_cnt_q;
        rx_valid_d = 1'b0;
        rx_start_d = rx_start_q;
        first_d    = first_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        miso_d     = miso_q;
        underrun_d = 1'b0;
        load       = 1'b0;
        pop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d  = ST_ACTIVE;
                    rx_cnt_d = '0;
                    tx_cnt_d = '0;
                    first_d  = 1'b1;
                    load     = (CPHA == 0);
                end
            end
            ST_ACTIVE: begin
                if (cs_s_q) begin
                    // Frame ended: any partial RX word and loaded TX word are abandoned.
                    state_d  = ST_IDLE;
                    rx_cnt_d = '0;
                    tx_cnt_d = '0;
                    miso_d   = 1'b0;
                end else begin
                    if (sample) begin
                        rx_shift_d = rx_next;
                        if (rx_cnt_q == CNT_LAST) begin
                            rx_cnt_d   = '0;
                            rx_data_d  = rx_next;
                            rx_valid_d = 1'b1;
                            rx_start_d = first_q;
                            first_d    = 1'b0;
                        end else begin
                            rx_cnt_d = rx_cnt_q + 1'b1;
                        end
                    end
                    if (shift) begin
                        if ((CPHA == 0) ? (tx_cnt_q == CNT_LAST) : (tx_cnt_q == '0)) begin
                            load = 1'b1;
                        end else begin
                            tx_shift_d = tx_next;
                            miso_d     = (MSB_FIRST != 0) ? tx_next[WIDTH-1] : tx_next[0];
                        end
                        tx_cnt_d = (tx_cnt_q == CNT_LAST) ? '0 : tx_cnt_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                miso_d = 1'b0;
                if (cs_s_q) state_d = ST_IDLE;
            end
            default: state_d = ST_HOLD;
        endcase

        if (load) begin
            pop        = !fifo_empty;
            underrun_d = fifo_empty;
            tx_shift_d = tx_word;
            miso_d     = (MSB_FIRST != 0) ? tx_word[WIDTH-1] : tx_word[0];
        end

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge i_spi_clk) begin
        if (i_reset) begin
            // Synchronised CS reads low after reset, so HOLD waits for a real CS high.
            state_q    <= ST_HOLD;
            sclk_m_q   <= 1'b0;
            sclk_s_q   <= 1'b0;
            sclk_p_q   <= 1'b0;
            cs_m_q     <= 1'b0;
            cs_s_q     <= 1'b0;
            cs_p_q     <= 1'b0;
            mosi_m_q   <= 1'b0;
            mosi_s_q   <= 1'b0;
            active_q   <= 1'b0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_cnt_q   <= '0;
            rx_valid_q <= 1'b0;
            rx_start_q <= 1'b0;
            first_q    <= 1'b0;
            tx_shift_q <= '0;
            tx_cnt_q   <= '0;
            miso_q     <= 1'b0;
            underrun_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            sclk_m_q   <= sclk_m_d;
            sclk_s_q   <= sclk_s_d;
            sclk_p_q   <= sclk_p_d;
            cs_m_q     <= cs_m_d;
            cs_s_q     <= cs_s_d;
            cs_p_q     <= cs_p_d;
            mosi_m_q   <= mosi_m_d;
            mosi_s_q   <= mosi_s_d;
            active_q   <= active_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_valid_q <= rx_valid_d;
            rx_start_q <= rx_start_d;
            first_q    <= first_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            miso_q     <= miso_d;
            underrun_q <= underrun_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    always_ff @(posedge i_spi_clk) begin
        if (push) fifo_mem[wr_ptr_q] <= i_tx_data;
    end

    assign o_miso        = miso_q;
    assign o_active      = active_q;
    assign o_rx_valid    = rx_valid_q;
    assign o_rx_start    = rx_start_q;
    assign o_rx_data     = rx_data_q;
    assign o_tx_underrun = underrun_q;
    assign o_tx_level    = level_q;
    assign o_dbg_state   = state_q;
endmodule

// File: tb/tb_spi_client_ovs.sv
// Bench for spi_client_ovs: two instances (8-bit mode 0 MSB-first, 12-bit mode 3
// LSB-first) driven by a bit-level SPI master against a queue-based reference model.
module tb_spi_client_ovs;
  localparam int W0 = 8;
  localparam int W1 = 12;
  localparam int DEPTH = 4;
  localparam int HALF = 8;
  localparam int QTR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic sclk [2];
  logic cs_n [2];
  logic mosi [2];
  logic tx_valid [2];
  logic [31:0] tx_data [2];
  logic miso [2];
  logic active [2];
  logic rx_valid [2];
  logic rx_start [2];
  logic tx_ready [2];
  logic underrun [2];
  logic [W0-1:0] rx_data0;
  logic [W1-1:0] rx_data1;
  logic [2:0] level0, level1;
  logic [1:0] dbg0, dbg1;

  spi_client_ovs #(.WIDTH(W0), .DEPTH(DEPTH), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) dut0 (
    .i_spi_clk(clk), .i_reset(rst), .i_sclk(sclk[0]), .i_cs_n(cs_n[0]), .i_mosi(mosi[0]),
    .o_miso(miso[0]), .o_active(active[0]), .o_rx_valid(rx_valid[0]), .o_rx_start(rx_start[0]),
    .o_rx_data(rx_data0), .i_tx_valid(tx_valid[0]), .o_tx_ready(tx_ready[0]),
    .i_tx_data(tx_data[0][W0-1:0]), .o_tx_underrun(underrun[0]), .o_tx_level(level0),
    .o_dbg_state(dbg0)
  );

  spi_client_ovs #(.WIDTH(W1), .DEPTH(DEPTH), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) dut1 (
    .i_spi_clk(clk), .i_reset(rst), .i_sclk(sclk[1]), .i_cs_n(cs_n[1]), .i_mosi(mosi[1]),
    .o_miso(miso[1]), .o_active(active[1]), .o_rx_valid(rx_valid[1]), .o_rx_start(rx_start[1]),
    .o_rx_data(rx_data1), .i_tx_valid(tx_valid[1]), .o_tx_ready(tx_ready[1]),
    .i_tx_data(tx_data[1][W1-1:0]), .o_tx_underrun(underrun[1]), .o_tx_level(level1),
    .o_dbg_state(dbg1)
  );

  // reference model and scoreboard state
  logic [31:0] fifo_m0 [$];
  logic [31:0] fifo_m1 [$];
  logic [32:0] exp_rx0 [$];
  logic [32:0] exp_rx1 [$];
  int ur_cnt [2];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wd(input int k);
    return (k != 0) ? W1 : W0;
  endfunction

  function automatic logic [31:0] mask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic int fifo_size(input int k);
    return (k != 0) ? fifo_m1.size() : fifo_m0.size();
  endfunction

  function automatic int rx_size(input int k);
    return (k != 0) ? exp_rx1.size() : exp_rx0.size();
  endfunction

  function automatic logic [31:0] get_level(input int k);
    return (k != 0) ? 32'(level1) : 32'(level0);
  endfunction

  function automatic logic [31:0] get_rx_data(input int k);
    return (k != 0) ? 32'(rx_data1) : 32'(rx_data0);
  endfunction

  function automatic void model_push(input int k, input logic [31:0] d);
    if (k != 0) fifo_m1.push_back(d);
    else fifo_m0.push_back(d);
  endfunction

  // {empty, data}: a load from an empty FIFO yields zero data
  function automatic logic [32:0] model_pop(input int k);
    if (fifo_size(k) == 0) return {1'b1, 32'd0};
    if (k != 0) return {1'b0, fifo_m1.pop_front()};
    return {1'b0, fifo_m0.pop_front()};
  endfunction

  function automatic void rx_push(input int k, input logic [32:0] v);
    if (k != 0) exp_rx1.push_back(v);
    else exp_rx0.push_back(v);
  endfunction

  // monitor: every o_rx_valid pulse consumes one expected word
  always @(negedge clk) begin
    logic [32:0] e;
    if (rx_valid[0]) begin
      if (exp_rx0.size() == 0) check("rx0_unexpected", 1, 0);
      else begin
        e = exp_rx0.pop_front();
        check("rx0_data", get_rx_data(0), e[31:0]);
        check("rx0_start", rx_start[0], e[32]);
      end
    end
    if (rx_valid[1]) begin
      if (exp_rx1.size() == 0) check("rx1_unexpected", 1, 0);
      else begin
        e = exp_rx1.pop_front();
        check("rx1_data", get_rx_data(1), e[31:0]);
        check("rx1_start", rx_start[1], e[32]);
      end
    end
    if (underrun[0]) ur_cnt[0]++;
    if (underrun[1]) ur_cnt[1]++;
  end

  task automatic push(input int k, input logic [31:0] d);
    logic ok;
    @(posedge clk); #1;
    tx_valid[k] = 1'b1;
    tx_data[k] = d & mask(wd(k));
    ok = (fifo_size(k) < DEPTH);
    check("tx_ready", tx_ready[k], ok);
    @(posedge clk); #1;
    tx_valid[k] = 1'b0;
    if (ok) model_push(k, d & mask(wd(k)));
    check("tx_level", get_level(k), fifo_size(k));
  endtask

  // One chip-select frame of nw full words plus pb bits of a partial word.
  // sim_push pushes sp_data in the cycle the cs fall is detected; rst_at >= 0
  // pulses i_reset before bit rst_at (must lie in the first word).
  task automatic frame(input int k, input int nw, input int pb, input bit use_fix,
                       input logic [31:0] fix, input bit sim_push, input logic [31:0] sp_data,
                       input int rst_at);
    int w, nbits, ur_exp, ur_base, wi, bi;
    logic pol, ph, msbf, dead, bitv, smp;
    logic [31:0] mo [$];
    logic [31:0] exp_tx [$];
    logic [31:0] got, cur;
    logic [32:0] pr;
    w = wd(k);
    pol = (k != 0);
    ph = (k != 0);
    msbf = (k == 0);
    nbits = nw * w + pb;
    for (int i = 0; i < nw + ((pb > 0) ? 1 : 0); i++)
      mo.push_back((i == 0 && use_fix) ? (fix & mask(w)) : ($urandom & mask(w)));
    ur_exp = 0;
    ur_base = ur_cnt[k];
    dead = 1'b0;
    got = '0;
    if (rst_at < 0)
      for (int i = 0; i < nw; i++) rx_push(k, {(i == 0), mo[i]});

    @(posedge clk); #1;
    cs_n[k] = 1'b0;
    if (ph == 1'b0) begin
      pr = model_pop(k);
      if (pr[32]) ur_exp++;
      exp_tx.push_back(pr[31:0]);
    end
    if (sim_push) begin
      repeat (2) @(posedge clk);
      #1;
      tx_valid[k] = 1'b1;
      tx_data[k] = sp_data & mask(w);
      @(posedge clk); #1;
      tx_valid[k] = 1'b0;
      model_push(k, sp_data & mask(w));
      check("lvl_simul", get_level(k), fifo_size(k));
    end
    repeat (HALF) @(posedge clk);
    #1;
    check("active_on", active[k], 1);

    for (int b = 0; b < nbits; b++) begin
      wi = b / w;
      bi = b % w;
      cur = mo[wi];
      bitv = msbf ? cur[w-1-bi] : cur[bi];
      if (b == rst_at) begin
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        dead = 1'b1;
        exp_tx.delete();
        fifo_m0.delete();
        fifo_m1.delete();
        check("rst_level", get_level(k), 0);
        check("rst_ready", tx_ready[k], 1);
        check("rst_rxdata", get_rx_data(k), 0);
        check("rst_miso", miso[k], 0);
      end
      if (ph == 1'b0) begin
        mosi[k] = bitv;
        repeat (QTR) @(posedge clk);
        #1;
        smp = miso[k];
        sclk[k] = ~pol;
        repeat (HALF) @(posedge clk);
        #1;
        sclk[k] = pol;
        if (bi == w - 1 && !dead) begin
          pr = model_pop(k);
          if (pr[32]) ur_exp++;
          exp_tx.push_back(pr[31:0]);
        end
        repeat (QTR) @(posedge clk);
        #1;
      end else begin
        sclk[k] = ~pol;
        mosi[k] = bitv;
        if (bi == 0 && !dead) begin
          pr = model_pop(k);
          if (pr[32]) ur_exp++;
          exp_tx.push_back(pr[31:0]);
        end
        repeat (HALF) @(posedge clk);
        #1;
        smp = miso[k];
        sclk[k] = pol;
        repeat (HALF) @(posedge clk);
        #1;
      end
      if (dead) check("miso_hold", smp, 0);
      else begin
        if (msbf) got[w-1-bi] = smp;
        else got[bi] = smp;
        if (bi == w - 1) begin
          check("miso_word", got, exp_tx.pop_front());
          got = '0;
        end
      end
    end

    repeat (HALF) @(posedge clk);
    #1;
    cs_n[k] = 1'b1;
    mosi[k] = 1'b0;
    repeat (2 * HALF) @(posedge clk);
    #1;
    check("active_off", active[k], 0);
    check("underrun_cnt", ur_cnt[k] - ur_base, ur_exp);
    check("rx_drain", rx_size(k), 0);
    check("level_end", get_level(k), fifo_size(k));
    check("miso_idle", miso[k], 0);
  endtask

  initial begin
    int n, nw, pb;
    for (int k = 0; k < 2; k++) begin
      sclk[k] = (k != 0);
      cs_n[k] = 1'b1;
      mosi[k] = 1'b0;
      tx_valid[k] = 1'b0;
      tx_data[k] = '0;
      ur_cnt[k] = 0;
    end
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst0_level", get_level(k), 0);
      check("rst0_ready", tx_ready[k], 1);
      check("rst0_rxvalid", rx_valid[k], 0);
      check("rst0_rxstart", rx_start[k], 0);
      check("rst0_rxdata", get_rx_data(k), 0);
      check("rst0_miso", miso[k], 0);
      check("rst0_underrun", underrun[k], 0);
      check("rst0_active", active[k], 0);
    end
    rst = 1'b0;
    repeat (10) @(posedge clk);

    // mode 0 single word round trip, then mode 3 two-word frame
    push(0, 32'hA5);
    frame(0, 1, 0, 1'b1, 32'h3C, 1'b0, 0, -1);
    push(1, 32'h12);
    push(1, 32'h34);
    frame(1, 2, 0, 1'b1, 32'h81, 1'b0, 0, -1);

    // empty FIFO at frame start
    frame(1, 1, 0, 1'b0, 0, 1'b0, 0, -1);
    frame(0, 1, 0, 1'b0, 0, 1'b0, 0, -1);

    // fill to full, refused fifth push, then same-cycle pop+push at level 3
    for (int i = 0; i < 5; i++) push(0, $urandom);
    frame(0, 0, 0, 1'b0, 0, 1'b0, 0, -1);
    frame(0, 1, 0, 1'b0, 0, 1'b1, 32'h77, -1);
    frame(0, 3, 0, 1'b0, 0, 1'b0, 0, -1);
    // same-cycle push into an empty FIFO is not bypassed to the load
    frame(0, 1, 0, 1'b0, 0, 1'b1, 32'h5C, -1);

    // aborted frame, then a full word starts a fresh frame
    frame(0, 0, 5, 1'b0, 0, 1'b0, 0, -1);
    frame(0, 1, 0, 1'b0, 0, 1'b0, 0, -1);

    // reset mid-frame, then a 12-bit LSB-first round trip
    push(1, 32'h123);
    frame(1, 1, 0, 1'b0, 0, 1'b0, 0, 5);
    push(1, 32'hABC);
    frame(1, 1, 0, 1'b1, 32'hABC, 1'b0, 0, -1);

    for (int r = 0; r < 16; r++) begin
      int k;
      k = $urandom_range(0, 1);
      n = $urandom_range(0, DEPTH - fifo_size(k));
      for (int i = 0; i < n; i++) push(k, $urandom);
      nw = $urandom_range(1, 3);
      pb = ($urandom_range(0, 1) != 0) ? $urandom_range(1, wd(k) - 1) : 0;
      frame(k, nw, pb, 1'b0, 0, 1'b0, 0, -1);
    end

    repeat (20) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
